// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL powerdown/reset sequencer.
package pll_seq_pkg;

   localparam int unsigned STATE_W  = 2;
   localparam int unsigned RELOCK_W = 8;

   // Raw state vector width, for anything that carries the state outside the FSM
   typedef logic [STATE_W-1:0] state_t;

   // Sequencer states
   typedef enum logic [STATE_W-1:0] {
      ST_PD        = 2'd0,
      ST_MCGB      = 2'd1,
      ST_WAIT_LOCK = 2'd2,
      ST_LOCKED    = 2'd3
   } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_share_reset_sequencer.sv
// Powerdown / MCGB reset / lock-qualification sequencer for one PLL shared by two requesters.
module pll_share_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PD_HOLD_CYCLES      = 100,
   parameter int unsigned MCGB_HOLD_CYCLES    = 20,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
   parameter int unsigned CNT_W               = 17
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pll_locked,
   input  logic                pll_powerdown_a,
   input  logic                pll_powerdown_b,
   output logic                pll_powerdown,
   output logic                mcgb_rst,
   output logic                pll_locked_output,
   output logic                pll_locked_a,
   output logic                pll_locked_b,
   output logic                timeout_err,
   output logic [RELOCK_W-1:0] relock_count
);

   localparam logic [CNT_W-1:0] PD_LAST      = CNT_W'(PD_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] MCGB_LAST    = CNT_W'(MCGB_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   pll_state_e          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    scnt_q;
   logic                pd_q;
   logic                mcgb_q;
   logic                locked_q;
   logic                locked_a_q;
   logic                locked_b_q;
   logic                timeout_q;
   logic [RELOCK_W-1:0] relock_q;

   logic                lock_s;
   logic                req_c;

   // Lock comes from the PLL analog domain; only the synchronized copy is used
   sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (pll_locked),
      .q_o   (lock_s)
   );

   // Either requester holding powerdown keeps the shared PLL down
   assign req_c = pll_powerdown_a | pll_powerdown_b;

   // Sequencer FSM, counters and registered outputs (outputs lag the state by one cycle)
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_PD;
         cnt_q      <= '0;
         scnt_q     <= '0;
         pd_q       <= 1'b1;
         mcgb_q     <= 1'b1;
         locked_q   <= 1'b0;
         locked_a_q <= 1'b0;
         locked_b_q <= 1'b0;
         timeout_q  <= 1'b0;
         relock_q   <= '0;
      end else begin
         pd_q       <= (state_q == ST_PD);
         mcgb_q     <= (state_q == ST_PD) || (state_q == ST_MCGB);
         locked_q   <= (state_q == ST_LOCKED);
         locked_a_q <= (state_q == ST_LOCKED) && !pll_powerdown_a;
         locked_b_q <= (state_q == ST_LOCKED) && !pll_powerdown_b;
         timeout_q  <= 1'b0;
         cnt_q      <= cnt_q + CNT_W'(1);
         scnt_q     <= '0;

         case (state_q)
            ST_PD: begin
               if (cnt_q == PD_LAST) begin
                  // Minimum hold met; stay parked until both requesters let go
                  if (!req_c) begin
                     state_q <= ST_MCGB;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q   <= cnt_q;
                  end
               end
            end

            ST_MCGB: begin
               if (req_c) begin
                  state_q <= ST_PD;
                  cnt_q   <= '0;
               end else if (cnt_q == MCGB_LAST) begin
                  state_q <= ST_WAIT_LOCK;
                  cnt_q   <= '0;
               end
            end

            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  scnt_q <= scnt_q + CNT_W'(1);
               end
               if (req_c) begin
                  state_q <= ST_PD;
                  cnt_q   <= '0;
                  scnt_q  <= '0;
               end else if (lock_s && (scnt_q == STABLE_LAST)) begin
                  // Lock wins over a coincident timeout
                  state_q <= ST_LOCKED;
                  cnt_q   <= '0;
                  scnt_q  <= '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_q   <= ST_PD;
                  cnt_q     <= '0;
                  scnt_q    <= '0;
                  timeout_q <= 1'b1;
               end
            end

            ST_LOCKED: begin
               cnt_q <= '0;
               if (req_c) begin
                  state_q <= ST_PD;
               end else if (!lock_s) begin
                  // Unrequested lock loss is counted; a request in the same cycle masks it
                  state_q <= ST_PD;
                  if (relock_q != {RELOCK_W{1'b1}}) begin
                     relock_q <= relock_q + RELOCK_W'(1);
                  end
               end
            end

            default: begin
               state_q <= ST_PD;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign pll_powerdown     = pd_q;
   assign mcgb_rst          = mcgb_q;
   assign pll_locked_output = locked_q;
   assign pll_locked_a      = locked_a_q;
   assign pll_locked_b      = locked_b_q;
   assign timeout_err       = timeout_q;
   assign relock_count      = relock_q;

endmodule

// File: tb/tb_pll_share_reset_sequencer.sv
// Self-checking bench for pll_share_reset_sequencer with a phase/elapsed-time reference model.
module tb_pll_share_reset_sequencer;

   localparam int PD_HOLD = 4;
   localparam int MCGB_HOLD = 2;
   localparam int STABLE = 8;
   localparam int TIMEOUT = 50;

   localparam int M_PD = 0;
   localparam int M_MCGB = 1;
   localparam int M_WAIT = 2;
   localparam int M_LOCK = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pll_locked = 1'b0;
   logic pll_powerdown_a = 1'b0;
   logic pll_powerdown_b = 1'b0;
   logic pll_powerdown, mcgb_rst, pll_locked_output, pll_locked_a, pll_locked_b, timeout_err;
   logic [7:0] relock_count;

   int vectors = 0;
   int miscompares = 0;

   pll_share_reset_sequencer #(
      .PD_HOLD_CYCLES      (PD_HOLD),
      .MCGB_HOLD_CYCLES    (MCGB_HOLD),
      .LOCK_STABLE_CYCLES  (STABLE),
      .LOCK_TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W               (8)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pll_locked        (pll_locked),
      .pll_powerdown_a   (pll_powerdown_a),
      .pll_powerdown_b   (pll_powerdown_b),
      .pll_powerdown     (pll_powerdown),
      .mcgb_rst          (mcgb_rst),
      .pll_locked_output (pll_locked_output),
      .pll_locked_a      (pll_locked_a),
      .pll_locked_b      (pll_locked_b),
      .timeout_err       (timeout_err),
      .relock_count      (relock_count)
   );

   always #5 clk = ~clk;

   // Reference model: current phase, cycles spent in it, length of the current lock-high run
   typedef struct {
      int mode;
      int t;
      int run;
      bit [1:0] sp;
      bit pd, mc, lo, la, lb, to;
      int rc;
   } mdl_t;

   function automatic mdl_t mdl_next(mdl_t c, bit rst, bit a, bit b, bit lk);
      mdl_t n = c;
      bit req = a | b;
      bit ls = c.sp[1];
      int go = c.mode;
      int t;
      int run;
      if (rst) begin
         n.mode = M_PD; n.t = 0; n.run = 0; n.sp = 2'b00;
         n.pd = 1; n.mc = 1; n.lo = 0; n.la = 0; n.lb = 0; n.to = 0; n.rc = 0;
         return n;
      end
      n.sp = {c.sp[0], lk};
      n.pd = (c.mode == M_PD);
      n.mc = (c.mode == M_PD) || (c.mode == M_MCGB);
      n.lo = (c.mode == M_LOCK);
      n.la = n.lo && !a;
      n.lb = n.lo && !b;
      n.to = 0;
      t = c.t + 1;
      run = (c.mode == M_WAIT && ls) ? c.run + 1 : 0;
      case (c.mode)
         M_PD:   if (t >= PD_HOLD && !req) go = M_MCGB;
         M_MCGB: if (req) go = M_PD; else if (t == MCGB_HOLD) go = M_WAIT;
         M_WAIT: begin
            if (req) go = M_PD;
            else if (ls && run == STABLE) go = M_LOCK;
            else if (t == TIMEOUT) begin go = M_PD; n.to = 1; end
         end
         default: begin
            if (req) go = M_PD;
            else if (!ls) begin go = M_PD; n.rc = (c.rc < 255) ? c.rc + 1 : 255; end
         end
      endcase
      if (go != c.mode) begin n.t = 0; n.run = 0; end
      else begin n.t = t; n.run = run; end
      n.mode = go;
      return n;
   endfunction

   mdl_t m;
   always @(posedge clk) m <= mdl_next(m, reset, pll_powerdown_a, pll_powerdown_b, pll_locked);

   logic [13:0] dut_v, mdl_v;
   assign dut_v = {pll_powerdown, mcgb_rst, pll_locked_output, pll_locked_a, pll_locked_b, timeout_err, relock_count};
   assign mdl_v = {m.pd, m.mc, m.lo, m.la, m.lb, m.to, 8'(m.rc)};

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int lock_cyc = -1;
      int pd_cnt = 0;
      int mc_only = 0;
      logic [13:0] rst_v = 14'b11_0000_0000_0000;
      pll_locked = 1'b1; pll_powerdown_a = 1'b0; pll_powerdown_b = 1'b0;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (dut_v !== rst_v) begin
            miscompares++;
            $display("FAIL reset_values got=%b exp=%b", dut_v, rst_v);
         end
      end
      reset = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         vectors++;
         if (dut_v !== mdl_v) begin
            miscompares++;
            $display("FAIL reset_seq cyc=%0d got=%b exp=%b", k, dut_v, mdl_v);
         end
         if (pll_powerdown) pd_cnt++;
         if (mcgb_rst && !pll_powerdown) mc_only++;
         if (lock_cyc < 0 && pll_locked_output) lock_cyc = k;
      end
      vectors++;
      if (lock_cyc !== 15) begin
         miscompares++;
         $display("FAIL lock_latency got=%0d exp=15", lock_cyc);
      end
      vectors++;
      if (pd_cnt !== PD_HOLD || mc_only !== MCGB_HOLD) begin
         miscompares++;
         $display("FAIL pd_mcgb_len got=%0d/%0d exp=%0d/%0d", pd_cnt, mc_only, PD_HOLD, MCGB_HOLD);
      end
   endtask

   task automatic test_req_pulse();
      for (int trial = 0; trial < 3; trial++) begin
         bit use_b = 1'($urandom_range(1, 0));
         int len = int'($urandom_range(6, 1));
         int exp_pd = (len > PD_HOLD) ? len : PD_HOLD;
         int pd_cnt = 0;
         int relock = -1;
         pll_powerdown_a = !use_b; pll_powerdown_b = use_b;
         for (int k = 0; k <= exp_pd + 16; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== mdl_v) begin
               miscompares++;
               $display("FAIL req_pulse k=%0d got=%b exp=%b", k, dut_v, mdl_v);
            end
            if (k == 0) begin
               vectors++;
               if ({pll_locked_output, pll_locked_a, pll_locked_b} !== {1'b1, use_b, !use_b}) begin
                  miscompares++;
                  $display("FAIL req_lock_drop got=%b exp=%b", {pll_locked_output, pll_locked_a, pll_locked_b},
                           {1'b1, use_b, !use_b});
               end
            end
            if (pll_powerdown) pd_cnt++;
            if (k > 0 && relock < 0 && pll_locked_output) relock = k;
            pll_powerdown_a = !use_b && (k + 1 < len);
            pll_powerdown_b = use_b && (k + 1 < len);
         end
         vectors++;
         if (pd_cnt !== exp_pd || relock !== exp_pd + 11 || relock_count !== 8'd0) begin
            miscompares++;
            $display("FAIL req_pulse_timing len=%0d pd=%0d relock=%0d rc=%0d exp=%0d/%0d/0",
                     len, pd_cnt, relock, relock_count, exp_pd, exp_pd + 11);
         end
      end
   endtask

   task automatic test_overlap();
      for (int trial = 0; trial < 3; trial++) begin
         int la = int'($urandom_range(8, 3));
         int s = int'($urandom_range(la - 1, 1));
         int lb = la - s + int'($urandom_range(5, 1));
         int tot = s + lb;
         int exp_pd = (tot > PD_HOLD) ? tot : PD_HOLD;
         int pd_cnt = 0;
         pll_powerdown_a = 1'b1; pll_powerdown_b = 1'b0;
         for (int k = 0; k <= exp_pd + 16; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== mdl_v) begin
               miscompares++;
               $display("FAIL overlap k=%0d got=%b exp=%b", k, dut_v, mdl_v);
            end
            if (pll_powerdown) pd_cnt++;
            pll_powerdown_a = (k + 1 < la);
            pll_powerdown_b = (k + 1 >= s) && (k + 1 < tot);
         end
         vectors++;
         if (pd_cnt !== exp_pd || pll_locked_output !== 1'b1) begin
            miscompares++;
            $display("FAIL overlap_pd_len got=%0d lock=%b exp=%0d lock=1", pd_cnt, pll_locked_output, exp_pd);
         end
      end
   endtask

   task automatic test_timeout();
      int pulses = 0;
      int first = -1;
      bit saw_lock = 0;
      pll_locked = 1'b0; pll_powerdown_a = 1'b0; pll_powerdown_b = 1'b0;
      apply_reset(2);
      for (int k = 1; k <= 170; k++) begin
         @(negedge clk);
         vectors++;
         if (dut_v !== mdl_v) begin
            miscompares++;
            $display("FAIL timeout_seq cyc=%0d got=%b exp=%b", k, dut_v, mdl_v);
         end
         if (timeout_err) begin pulses++; if (first < 0) first = k; end
         if (pll_locked_output || pll_locked_a || pll_locked_b) saw_lock = 1;
      end
      vectors++;
      if (pulses !== 3 || first !== 56 || saw_lock) begin
         miscompares++;
         $display("FAIL timeout_loop pulses=%0d first=%0d lock=%0d exp=3/56/0", pulses, first, saw_lock);
      end
   endtask

   task automatic test_toggle();
      int ph = int'($urandom_range(9, 0));
      int pulses = 0;
      int first = -1;
      bit saw_lock = 0;
      pll_locked = 1'(((ph) / 5) % 2);
      apply_reset(2);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         vectors++;
         if (dut_v !== mdl_v) begin
            miscompares++;
            $display("FAIL toggle_seq cyc=%0d got=%b exp=%b", k, dut_v, mdl_v);
         end
         if (timeout_err) begin pulses++; if (first < 0) first = k; end
         if (pll_locked_output) saw_lock = 1;
         pll_locked = 1'(((k + ph) / 5) % 2);
      end
      vectors++;
      if (pulses !== 1 || first !== 56 || saw_lock) begin
         miscompares++;
         $display("FAIL toggle_no_lock pulses=%0d first=%0d lock=%0d exp=1/56/0", pulses, first, saw_lock);
      end
   endtask

   task automatic test_relock();
      pll_locked = 1'b1; pll_powerdown_a = 1'b0; pll_powerdown_b = 1'b0;
      apply_reset(2);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         vectors++;
         if (dut_v !== mdl_v) begin
            miscompares++;
            $display("FAIL relock_init cyc=%0d got=%b exp=%b", k, dut_v, mdl_v);
         end
      end
      for (int i = 0; i < 300; i++) begin
         int d = int'($urandom_range(4, 1));
         bit done = 0;
         pll_locked = 1'b0;
         for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== mdl_v) begin
               miscompares++;
               $display("FAIL relock_seq it=%0d k=%0d got=%b exp=%b", i, k, dut_v, mdl_v);
            end
            if (k >= d + 4 && pll_locked_output) done = 1;
            pll_locked = (k + 1 >= d);
         end
         if (!done) begin
            miscompares++;
            $display("FAIL relock_wait it=%0d got=no_lock exp=lock_within_80", i);
            break;
         end
         if (i == 0) begin
            vectors++;
            if (relock_count !== 8'd1) begin
               miscompares++;
               $display("FAIL relock_first got=%0d exp=1", relock_count);
            end
         end
      end
      vectors++;
      if (relock_count !== 8'd255) begin
         miscompares++;
         $display("FAIL relock_saturate got=%0d exp=255", relock_count);
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] rst_v = 14'b11_0000_0000_0000;
      pll_locked = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         vectors++;
         if (dut_v !== mdl_v) begin
            miscompares++;
            $display("FAIL mid_pre k=%0d got=%b exp=%b", k, dut_v, mdl_v);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (dut_v !== rst_v) begin
         miscompares++;
         $display("FAIL mid_reset got=%b exp=%b", dut_v, rst_v);
      end
   endtask

   task automatic test_random();
      pll_locked = 1'b1; pll_powerdown_a = 1'b0; pll_powerdown_b = 1'b0;
      apply_reset(2);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         vectors++;
         if (dut_v !== mdl_v) begin
            miscompares++;
            $display("FAIL random cyc=%0d got=%b exp=%b", k, dut_v, mdl_v);
         end
         reset = ($urandom_range(799, 0) == 0);
         if (pll_powerdown_a) pll_powerdown_a = ($urandom_range(3, 0) != 0);
         else                 pll_powerdown_a = ($urandom_range(59, 0) == 0);
         if (pll_powerdown_b) pll_powerdown_b = ($urandom_range(3, 0) != 0);
         else                 pll_powerdown_b = ($urandom_range(59, 0) == 0);
         if (pll_locked) pll_locked = ($urandom_range(79, 0) != 0);
         else            pll_locked = ($urandom_range(5, 0) == 0);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_req_pulse();
      test_overlap();
      test_timeout();
      test_toggle();
      test_relock();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=no_finish exp=finish_before_2ms");
      $fatal(1, "watchdog expired");
   end

endmodule
